// File: rtl/mode_ctrl_pkg.sv
// rtl/mode_ctrl_pkg.sv - shared state enum, default sizing and index-width helper for the mode controller
package mode_ctrl_pkg;

   typedef enum logic {
      MENU   = 1'b0,
      ACTIVE = 1'b1
   } mode_state_e;

   localparam int DEF_NUM_MODES       = 4;
   localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;

   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, run-length debouncer and single press pulse
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int RW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync0_q, sync1_q, samp_q;
   logic          level_q, level_d;
   logic          armed_q, armed_d;
   logic          press_q, press_d;
   logic [RW-1:0] run_q, run_d;
   logic          stable;

   // run_q counts consecutive identical synchronized samples, saturating at the window length
   always_comb begin
      run_d = run_q;
      if (sync1_q != samp_q) begin
         run_d = RW'(1);
      end else if (run_q != RW'(DEBOUNCE_CYCLES)) begin
         run_d = run_q + 1'b1;
      end
      stable  = (run_d == RW'(DEBOUNCE_CYCLES));
      level_d = stable ? sync1_q : level_q;
      // a press only counts once a debounced release has been seen since reset
      armed_d = armed_q | (stable & ~sync1_q);
      press_d = stable & sync1_q & ~level_q & armed_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync0_q <= 1'b0;
         sync1_q <= 1'b0;
         samp_q  <= 1'b0;
         run_q   <= '0;
         level_q <= 1'b0;
         armed_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync0_q <= btn;
         sync1_q <= sync0_q;
         samp_q  <= sync1_q;
         run_q   <= run_d;
         level_q <= level_d;
         armed_q <= armed_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/mode_ctrl_fsm.sv
// rtl/mode_ctrl_fsm.sv - MENU/ACTIVE mode selector with cursor, one-hot mode enable and change pulse
module mode_ctrl_fsm
   import mode_ctrl_pkg::*;
#(
   parameter int NUM_MODES       = DEF_NUM_MODES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int IW              = idx_width(NUM_MODES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 switch_btn,
   input  logic                 confirm_btn,
   input  logic                 back_btn,
   input  logic [NUM_MODES-1:0] mode_done,
   output logic [IW-1:0]        cursor,
   output logic [IW-1:0]        active_mode,
   output logic                 in_menu,
   output logic [NUM_MODES-1:0] mode_en,
   output logic                 mode_changed
);

   logic switch_p, confirm_p, back_p;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_switch (
      .clk(clk), .rst(rst), .btn(switch_btn), .press(switch_p)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm (
      .clk(clk), .rst(rst), .btn(confirm_btn), .press(confirm_p)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
      .clk(clk), .rst(rst), .btn(back_btn), .press(back_p)
   );

   mode_state_e          state_q, state_d;
   logic [IW-1:0]        cursor_q, cursor_d;
   logic [IW-1:0]        active_q, active_d;
   logic                 in_menu_q, in_menu_d;
   logic [NUM_MODES-1:0] mode_en_q, mode_en_d;
   logic                 changed_q, changed_d;
   logic                 done_hit;

   always_comb begin
      state_d   = state_q;
      cursor_d  = cursor_q;
      active_d  = active_q;
      in_menu_d = in_menu_q;
      mode_en_d = mode_en_q;
      changed_d = 1'b0;
      done_hit  = mode_done[active_q];
      case (state_q)
         MENU: begin
            // confirm wins over a same-cycle switch, so the mode entered is the un-incremented cursor
            if (confirm_p) begin
               state_d   = ACTIVE;
               active_d  = cursor_q;
               mode_en_d = NUM_MODES'(1) << cursor_q;
               in_menu_d = 1'b0;
               changed_d = 1'b1;
            end else if (switch_p) begin
               cursor_d = (cursor_q == IW'(NUM_MODES - 1)) ? '0 : cursor_q + 1'b1;
            end
         end
         ACTIVE: begin
            if (back_p || done_hit) begin
               state_d   = MENU;
               cursor_d  = active_q;
               mode_en_d = '0;
               in_menu_d = 1'b1;
               changed_d = 1'b1;
            end
         end
         default: begin
            state_d   = MENU;
            mode_en_d = '0;
            in_menu_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= MENU;
         cursor_q  <= '0;
         active_q  <= '0;
         in_menu_q <= 1'b1;
         mode_en_q <= '0;
         changed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cursor_q  <= cursor_d;
         active_q  <= active_d;
         in_menu_q <= in_menu_d;
         mode_en_q <= mode_en_d;
         changed_q <= changed_d;
      end
   end

   assign cursor       = cursor_q;
   assign active_mode  = active_q;
   assign in_menu      = in_menu_q;
   assign mode_en      = mode_en_q;
   assign mode_changed = changed_q;

endmodule

// File: tb/tb_mode_ctrl_fsm.sv
// tb/tb_mode_ctrl_fsm.sv - scoreboard bench for mode_ctrl_fsm with short debounce window
module tb_mode_ctrl_fsm;

   localparam int N = 8;
   localparam int M = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         sw = 1'b0, cf = 1'b0, bk = 1'b0;
   logic [M-1:0] done = '0;
   logic [1:0]   cursor, active_mode;
   logic         in_menu, mode_changed;
   logic [M-1:0] mode_en;

   mode_ctrl_fsm #(.NUM_MODES(M), .DEBOUNCE_CYCLES(N)) dut (
      .clk(clk), .rst(rst), .switch_btn(sw), .confirm_btn(cf), .back_btn(bk),
      .mode_done(done), .cursor(cursor), .active_mode(active_mode),
      .in_menu(in_menu), .mode_en(mode_en), .mode_changed(mode_changed)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]   cur;
      logic [1:0]   act;
      logic         menu;
      logic [M-1:0] en;
   } snap_t;

   snap_t exp_q[$];
   snap_t obs_q[$];
   snap_t last_s, cur_s, e, o;
   int    vectors = 0, miscompares = 0, chg_cnt = 0, chg_base;

   // active_mode is only meaningful outside MENU, so it is masked there
   always @(negedge clk) begin
      cur_s = '{cursor, (in_menu ? 2'd0 : active_mode), in_menu, mode_en};
      if (rst && cur_s != last_s) obs_q.push_back(cur_s);
      last_s = cur_s;
      if (mode_changed) chg_cnt++;
   end

   task automatic press(input int which, input int hold);
      @(posedge clk); #2;
      case (which)
         0: sw = 1'b1;
         1: cf = 1'b1;
         2: bk = 1'b1;
         default: begin sw = 1'b1; cf = 1'b1; end
      endcase
      repeat (hold) @(posedge clk);
      #2; sw = 1'b0; cf = 1'b0; bk = 1'b0;
      repeat (N + 8) @(posedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({cursor, active_mode, in_menu, mode_en, mode_changed} !== {2'd0, 2'd0, 1'b1, 4'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_outputs: got cur=%0d act=%0d menu=%b en=%b chg=%b, want 0 0 1 0000 0",
                  cursor, active_mode, in_menu, mode_en, mode_changed);
      end
      @(posedge clk); #2; rst = 1'b1;
      repeat (N + 10) @(posedge clk);
      obs_q.delete();
   endtask

   task automatic test_switch;
      chg_base = chg_cnt;
      for (int i = 1; i <= 5; i++) begin
         exp_q.push_back('{2'(i % M), 2'd0, 1'b1, 4'b0});
         press(0, 20);
      end
      for (int t = 0; t < 300 && obs_q.size() < exp_q.size(); t++) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin
            miscompares++; $display("FAIL switch_seq: no output, want %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin miscompares++; $display("FAIL switch_seq: got %h want %h", o, e); end
         end
      end
      vectors++;
      if (chg_cnt !== chg_base || obs_q.size() != 0) begin
         miscompares++; $display("FAIL switch_quiet: chg=%0d extra=%0d want 0 0", chg_cnt - chg_base, obs_q.size());
      end
      obs_q.delete();
   endtask

   task automatic test_confirm;
      chg_base = chg_cnt;
      exp_q.push_back('{2'd2, 2'd0, 1'b1, 4'b0});
      press(0, 20);
      exp_q.push_back('{2'd2, 2'd2, 1'b0, 4'b0100});
      press(1, 20);
      press(0, 20);
      for (int t = 0; t < 300 && obs_q.size() < exp_q.size(); t++) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin
            miscompares++; $display("FAIL confirm: no output, want %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin miscompares++; $display("FAIL confirm: got %h want %h", o, e); end
         end
      end
      vectors++;
      if (chg_cnt - chg_base != 1 || obs_q.size() != 0 || cursor !== 2'd2) begin
         miscompares++;
         $display("FAIL confirm_hold: chg=%0d extra=%0d cur=%0d want 1 0 2", chg_cnt - chg_base, obs_q.size(), cursor);
      end
      obs_q.delete();
   endtask

   task automatic test_done;
      chg_base = chg_cnt;
      @(posedge clk); #2; done = 4'b0001;
      repeat (20) @(posedge clk);
      vectors++;
      if (obs_q.size() != 0 || chg_cnt != chg_base) begin
         miscompares++; $display("FAIL done_other: extra=%0d chg=%0d want 0 0", obs_q.size(), chg_cnt - chg_base);
      end
      exp_q.push_back('{2'd2, 2'd0, 1'b1, 4'b0});
      #2; done = 4'b0100;
      @(posedge clk); #2; done = 4'b0000;
      repeat (10) @(posedge clk);
      for (int t = 0; t < 300 && obs_q.size() < exp_q.size(); t++) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin
            miscompares++; $display("FAIL done_exit: no output, want %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin miscompares++; $display("FAIL done_exit: got %h want %h", o, e); end
         end
      end
      vectors++;
      if (chg_cnt - chg_base != 1 || obs_q.size() != 0) begin
         miscompares++; $display("FAIL done_pulse: chg=%0d extra=%0d want 1 0", chg_cnt - chg_base, obs_q.size());
      end
      obs_q.delete();
   endtask

   task automatic test_glitch;
      @(posedge clk); #2; sw = 1'b1;
      repeat (5) @(posedge clk);
      #2; sw = 1'b0;
      repeat (30) @(posedge clk);
      vectors++;
      if (obs_q.size() != 0) begin
         miscompares++; $display("FAIL glitch: extra=%0d cur=%0d want 0 2", obs_q.size(), cursor);
      end
      exp_q.push_back('{2'd3, 2'd0, 1'b1, 4'b0});
      press(0, 50);
      for (int t = 0; t < 300 && obs_q.size() < exp_q.size(); t++) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin
            miscompares++; $display("FAIL long_hold: no output, want %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin miscompares++; $display("FAIL long_hold: got %h want %h", o, e); end
         end
      end
      vectors++;
      if (obs_q.size() != 0) begin
         miscompares++; $display("FAIL long_hold_once: extra=%0d want 0", obs_q.size());
      end
      obs_q.delete();
   endtask

   task automatic test_simultaneous;
      chg_base = chg_cnt;
      exp_q.push_back('{2'd0, 2'd0, 1'b1, 4'b0});
      press(0, 20);
      exp_q.push_back('{2'd1, 2'd0, 1'b1, 4'b0});
      press(0, 20);
      exp_q.push_back('{2'd1, 2'd1, 1'b0, 4'b0010});
      press(3, 20);
      for (int t = 0; t < 300 && obs_q.size() < exp_q.size(); t++) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin
            miscompares++; $display("FAIL simultaneous: no output, want %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin miscompares++; $display("FAIL simultaneous: got %h want %h", o, e); end
         end
      end
      vectors++;
      if (chg_cnt - chg_base != 1 || obs_q.size() != 0) begin
         miscompares++; $display("FAIL simultaneous_pulse: chg=%0d extra=%0d want 1 0", chg_cnt - chg_base, obs_q.size());
      end
      obs_q.delete();
   endtask

   task automatic test_reset_mid;
      @(posedge clk); #2; bk = 1'b1;
      repeat (3) @(posedge clk);
      chg_base = chg_cnt;
      #2; rst = 1'b0;
      #1;
      vectors++;
      if ({cursor, active_mode, in_menu, mode_en, mode_changed} !== {2'd0, 2'd0, 1'b1, 4'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL async_reset: got cur=%0d act=%0d menu=%b en=%b chg=%b, want 0 0 1 0000 0",
                  cursor, active_mode, in_menu, mode_en, mode_changed);
      end
      repeat (3) @(posedge clk);
      #2; rst = 1'b1;
      repeat (N + 10) @(posedge clk);
      obs_q.delete();
      // enter mode 0 while back is still held from before the reset
      exp_q.push_back('{2'd0, 2'd0, 1'b0, 4'b0001});
      @(posedge clk); #2; cf = 1'b1;
      repeat (20) @(posedge clk);
      #2; cf = 1'b0;
      repeat (40) @(posedge clk);
      #2; bk = 1'b0;
      repeat (N + 8) @(posedge clk);
      exp_q.push_back('{2'd0, 2'd0, 1'b1, 4'b0});
      press(2, 20);
      for (int t = 0; t < 300 && obs_q.size() < exp_q.size(); t++) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin
            miscompares++; $display("FAIL held_back: no output, want %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin miscompares++; $display("FAIL held_back: got %h want %h", o, e); end
         end
      end
      vectors++;
      if (chg_cnt - chg_base != 2 || obs_q.size() != 0) begin
         miscompares++; $display("FAIL reset_pulses: chg=%0d extra=%0d want 2 0", chg_cnt - chg_base, obs_q.size());
      end
   endtask

   initial begin
      last_s = '0;
      test_reset();
      test_switch();
      test_confirm();
      test_done();
      test_glitch();
      test_simultaneous();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mode_ctrl_fsm.md
MODE_CTRL_FSM -- requirements
Module: mode_ctrl_fsm

Interface
REQ-001 Parameter: NUM_MODES, default 4, number of selectable play modes (>=2); index 0 is the first mode after MENU.
REQ-002 Parameter: DEBOUNCE_CYCLES, default 1_000_000, stable-input cycles required before a button press is accepted (10 ms at 100 MHz).
REQ-003 Derived constant: IW = max(1, clog2(NUM_MODES)), the mode index width.
REQ-004 Port: clk  in  1  single system clock, rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-low reset.
REQ-006 Port: switch_btn  in  1  raw, asynchronous "next mode" push button.
REQ-007 Port: confirm_btn  in  1  raw, asynchronous "enter mode" push button.
REQ-008 Port: back_btn  in  1  raw, asynchronous "return to menu" push button.
REQ-009 Port: mode_done  in  NUM_MODES  per-mode completion level, e.g. autoplay finished.
REQ-010 Port: cursor  out  IW  mode index currently highlighted on the display.
REQ-011 Port: active_mode  out  IW  index of the running mode, valid when in_menu=0.
REQ-012 Port: in_menu  out  1  high while in the MENU state.
REQ-013 Port: mode_en  out  NUM_MODES  one-hot enable for the running mode; all zero in MENU.
REQ-014 Port: mode_changed  out  1  one-cycle pulse on every MENU<->ACTIVE transition.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer, then a debouncer whose accepted level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-016 Each debouncer SHALL emit a 1-cycle press pulse on a released->pressed change of its accepted level; holding a button SHALL produce exactly one pulse.
REQ-017 The press pulse SHALL occur between DEBOUNCE_CYCLES and DEBOUNCE_CYCLES+3 cycles after a clean rising input edge.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES SHALL produce no pulse.
REQ-019 The FSM SHALL have two states: MENU and ACTIVE.
REQ-020 In MENU, a switch pulse SHALL set cursor to (cursor+1) mod NUM_MODES on the next edge; cursor NUM_MODES-1 wraps to 0.
REQ-021 In MENU, a confirm pulse SHALL move to ACTIVE with active_mode=cursor, mode_en=1<<cursor, in_menu=0 and mode_changed=1, all on the next edge.
REQ-022 In ACTIVE, a back pulse or mode_done[active_mode]=1 SHALL return to MENU with mode_en=0, in_menu=1 and mode_changed=1; cursor SHALL keep the last active_mode value.
REQ-023 In ACTIVE, switch and confirm pulses SHALL be ignored and cursor SHALL be held.
REQ-024 mode_done bits other than mode_done[active_mode], and all mode_done bits in MENU, SHALL be ignored.
REQ-025 On simultaneous events in the same cycle, priority SHALL be back/done > confirm > switch; in MENU, confirm+switch enters the mode at the current, un-incremented cursor.
REQ-026 All outputs SHALL be registered; mode_en SHALL never have more than one bit set.

Reset
REQ-027 With rst=0, outputs SHALL immediately become: state MENU, cursor=0, active_mode=0, mode_en=0, in_menu=1, mode_changed=0.
REQ-028 With rst=0, debouncer counters SHALL clear, accepted levels SHALL be "released" and synchronizers SHALL clear.
REQ-029 A reset asserted mid-ACTIVE SHALL abandon the mode without generating a mode_changed pulse.
REQ-030 A button held through reset release SHALL not generate a press pulse until it is released and pressed again.

Structure
REQ-031 The shared package mode_ctrl_pkg SHALL hold the state enum (MENU, ACTIVE), the default NUM_MODES and DEBOUNCE_CYCLES values, and the IW width function.
REQ-032 The debouncer SHALL be a sub-module, btn_debounce (synchronizer, counter, press pulse), instantiated three times; the FSM, cursor and enable logic SHALL be in mode_ctrl_fsm.

Verification (DEBOUNCE_CYCLES=8, NUM_MODES=4)
REQ-033 Reset, then press switch 5 times, each press held 20 cycles -> cursor sequence 1,2,3,0,1; in_menu stays 1; mode_en=0.
REQ-034 Cursor=2, press confirm -> mode_en=4'b0100, active_mode=2, one mode_changed pulse; a following switch press leaves cursor=2.
REQ-035 ACTIVE mode 2, drive mode_done=4'b0001 -> no change; then drive mode_done=4'b0100 -> MENU, mode_en=0, cursor=2, one mode_changed pulse.
REQ-036 Pulse switch high for 5 cycles -> no cursor change; hold it for 50 cycles -> exactly one increment.
REQ-037 In MENU at cursor=1, press confirm and switch on the same cycle -> active_mode=1, mode_en=4'b0010.
REQ-038 In ACTIVE, pull rst low mid-mode -> all outputs take their reset values asynchronously; with back held across reset release, no pulse occurs until back is re-pressed.
